// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int MAX_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 3;

  localparam int M_CPU = 0;
  localparam int M_DMA = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/data bundle of one memory port; master drives requests and write beats, slave returns reads.
interface mem_arbiter_if #(
  parameter int CNT_W = 3
);

  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_len;
  logic [3:0]       req_mask;
  logic [31:0]      req_addr;
  logic             req_we;
  logic             write_valid;
  logic [31:0]      write_data;
  logic             read_valid;
  logic [31:0]      read_data;
  logic             read_ack;

  modport master (
    output req_valid, req_len, req_mask, req_addr, req_we,
    output write_valid, write_data, read_ack,
    input  req_ready, read_valid, read_data
  );

  modport slave (
    input  req_valid, req_len, req_mask, req_addr, req_we,
    input  write_valid, write_data, read_ack,
    output req_ready, read_valid, read_data
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection: a lone requester wins, a tie goes to the master named by i_ptr.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_req[M_CPU] && i_req[M_DMA]) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end else if (i_req[M_CPU]) begin
      o_grant = 2'b01;
    end else if (i_req[M_DMA]) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (m0 = CPU, m1 = DMA/video) burst arbiter in front of one memory slave.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise m0 always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic [1:0]    grant,
  output logic          busy
);

  state_e           r_state;
  state_e           w_next_state;
  logic [1:0]       r_grant;
  logic [1:0]       w_pick;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             w_ptr;
  logic             w_owner;
  logic             w_hs;
  logic             w_beat;
  logic             w_last;

  logic             w_o_req_valid;
  logic [CNT_W-1:0] w_o_len;
  logic [CNT_W-1:0] w_len_clamp;
  logic [3:0]       w_o_mask;
  logic [31:0]      w_o_addr;
  logic             w_o_we;
  logic             w_o_wvalid;
  logic [31:0]      w_o_wdata;
  logic             w_o_ack;

  // Zero-length bursts become single beats; oversize bursts are cut to one line.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    if (len == '0) begin
      return CNT_W'(1);
    end else if (len > CNT_W'(MAX_LEN)) begin
      return CNT_W'(MAX_LEN);
    end else begin
      return len;
    end
  endfunction

  assign w_owner       = r_grant[M_DMA];
  assign w_o_req_valid = w_owner ? m1.req_valid   : m0.req_valid;
  assign w_o_len       = w_owner ? m1.req_len     : m0.req_len;
  assign w_o_mask      = w_owner ? m1.req_mask    : m0.req_mask;
  assign w_o_addr      = w_owner ? m1.req_addr    : m0.req_addr;
  assign w_o_we        = w_owner ? m1.req_we      : m0.req_we;
  assign w_o_wvalid    = w_owner ? m1.write_valid : m0.write_valid;
  assign w_o_wdata     = w_owner ? m1.write_data  : m0.write_data;
  assign w_o_ack       = w_owner ? m1.read_ack    : m0.read_ack;
  assign w_len_clamp   = clamp_len(w_o_len);

  assign w_hs   = (r_state == ADDR) && w_o_req_valid && s.req_ready;
  assign w_last = (r_cnt + CNT_W'(1)) == r_len;

  assign m0.read_data = s.read_data;
  assign m1.read_data = s.read_data;

  assign grant = r_grant;
  assign busy  = (r_state != IDLE);

  mem_arb_pick u_pick (
    .i_req   ({m1.req_valid, m0.req_valid}),
    .i_ptr   (w_ptr),
    .o_grant (w_pick)
  );

`ifdef MEM_ARBITER_RR_EN
  logic r_ptr;

  // After a completed transaction the other master gets the next tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= 1'(M_CPU);
    end else if ((r_state == DATA) && w_beat && w_last) begin
      r_ptr <= ~w_owner;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'(M_CPU);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_len   <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: r_grant <= w_pick;
        ADDR: begin
          if (w_hs) begin
            r_len <= w_len_clamp;
            r_we  <= w_o_we;
            r_cnt <= '0;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_grant <= 2'b00;
            end
          end
        end
        default: r_grant <= 2'b00;
      endcase
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_beat         = 1'b0;
    s.req_valid    = 1'b0;
    s.req_len      = w_len_clamp;
    s.req_mask     = w_o_mask;
    s.req_addr     = w_o_addr;
    s.req_we       = w_o_we;
    s.write_valid  = 1'b0;
    s.write_data   = w_o_wdata;
    s.read_ack     = 1'b0;
    m0.req_ready   = 1'b0;
    m1.req_ready   = 1'b0;
    m0.read_valid  = 1'b0;
    m1.read_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_pick) begin
          w_next_state = ADDR;
        end
      end
      ADDR: begin
        s.req_valid  = w_o_req_valid;
        m0.req_ready = ~w_owner & s.req_ready;
        m1.req_ready =  w_owner & s.req_ready;
        if (w_hs) begin
          w_next_state = DATA;
        end
      end
      DATA: begin
        if (r_we) begin
          s.write_valid = w_o_wvalid;
          w_beat        = w_o_wvalid;
        end else begin
          s.read_ack    = w_o_ack;
          m0.read_valid = ~w_owner & s.read_valid;
          m1.read_valid =  w_owner & s.read_valid;
          w_beat        = s.read_valid & w_o_ack;
        end
        if (w_beat && w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 4, giving the maximum beats per transaction (line burst).
REQ-002 SHALL have parameter CNT_W, default 3, giving the width of the beat counter and of req_len.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_/m1_ req_valid in 1, req_ready out 1, req_len in CNT_W, req_mask in 4, req_addr in 32, req_we in 1: per-master request (m0 = CPU bus interface, m1 = DMA/video).
REQ-006 SHALL have ports m0_/m1_ write_valid in 1, write_data in 32, read_valid out 1, read_data out 32, read_ack in 1: per-master data beats.
REQ-007 SHALL have slave ports s_req_valid out, s_req_ready in, s_req_len/mask/addr/we out, s_write_valid/s_write_data out, s_read_valid/s_read_data in, s_read_ack out, with the same widths as the master ports.
REQ-008 SHALL have ports grant  out  2  one-hot current owner, and busy  out  1  transaction in progress.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-010 IDLE: when any m*_req_valid=1, SHALL register the winner into grant and enter ADDR next cycle (1-cycle arbitration latency); the loser stays pending.
REQ-011 Both masters valid in the same IDLE cycle: SHALL pick the master indicated by the priority pointer; the pointer resets to m0.
REQ-012 ADDR: SHALL drive s_req_* combinationally from the owner; owner req_ready = s_req_ready; non-owner req_ready = 0.
REQ-013 On the s_req_valid & s_req_ready handshake: SHALL latch len and we, clear the beat counter, and enter DATA.
REQ-014 req_len of 0 SHALL be treated as 1; req_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-015 DATA write: s_write_valid/s_write_data SHALL follow the owner's signals; the non-owner's write_valid SHALL be ignored; each s_write_valid counts one beat.
REQ-016 DATA read: s_read_ack = owner read_ack; owner read_valid = s_read_valid; non-owner read_valid = 0; read_data SHALL be broadcast to both masters; each s_read_valid & s_read_ack counts one beat.
REQ-017 On the beat that makes count == len: SHALL return to IDLE the next cycle, set grant to 0, and update the priority pointer.
REQ-018 A request arriving while busy SHALL wait, never be dropped, and need not hold stable before its own grant.
REQ-019 busy SHALL be 1 in ADDR and DATA and 0 in IDLE.

Reset
REQ-020 rst_ni low SHALL immediately force IDLE, grant=0, busy=0, s_req_valid=0, s_write_valid=0, s_read_ack=0, m*_req_ready=0, m*_read_valid=0, counter=0, pointer=m0.
REQ-021 Reset mid-transaction SHALL abandon the beat without completing it; after release the FSM restarts from IDLE within 1 cycle.

Configuration
REQ-022 With MEM_ARBITER_RR_EN defined: the pointer SHALL toggle to the non-owner after each completed transaction (round robin).
REQ-023 Without MEM_ARBITER_RR_EN: m0 SHALL always win ties (fixed priority) and the pointer logic SHALL be absent.

Structure
REQ-024 Package mem_arb_pkg SHALL hold the state enum (IDLE/ADDR/DATA), MAX_LEN default, and master index constants M_CPU=0, M_DMA=1.
REQ-025 The winner selection SHALL live in sub-module mem_arb_pick (request pair + pointer -> one-hot grant); all other logic SHALL be in mem_arbiter.

Verification
REQ-026 m0 read, len=1, addr 0x0000_1000; slave returns 0xDEADBEEF -> m0 read_valid for 1 beat with that data, m1 read_valid stays 0, busy drops after the beat.
REQ-027 m1 write, len=4, data 0x1..0x4 -> s_write_data shows 0x1,0x2,0x3,0x4 in order, s_req_len=4, grant=2'b10 throughout.
REQ-028 m0 and m1 valid in the same cycle, twice in a row -> RR build: m0 then m1; fixed-priority build: m0 both times.
REQ-029 m1 requests during an m0 4-beat line read -> m1 req_ready stays 0 until m0's 4th beat, then m1 is granted 1 cycle after IDLE.
REQ-030 rst_ni low after the 2nd beat of a 4-beat read -> all outputs are at reset values in the same cycle; a new m0 request after release completes normally.
REQ-031 req_len=0 and req_len=7 -> s_req_len is 1 and 4 respectively, and the transaction ends after that many beats.
